// File: rtl/pe_weight_loader_pkg.sv
// Shared parameters, state encoding and helpers for the PE core weight/bias loader.
package pe_weight_loader_pkg;

    localparam int WEIGHT_WIDTH     = 16;
    localparam int BIAS_WIDTH       = 32;
    localparam int PE_NUM_PRE_CORE  = 3;
    localparam int CORE_NUM         = 8;
    localparam int ADDR_WIDTH       = 16;

    localparam int WEIGHTS_PER_CORE = PE_NUM_PRE_CORE * PE_NUM_PRE_CORE;
    localparam int KERNEL_WORDS     = WEIGHTS_PER_CORE + 1;

    localparam int CORE_CNT_W = $clog2(CORE_NUM + 1);
    localparam int CORE_IDX_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam int ELEM_W     = $clog2(KERNEL_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [CORE_NUM-1:0] core_onehot(input logic [CORE_IDX_W-1:0] idx);
        logic [CORE_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pe_weight_loader_if.sv
// Weight buffer read port plus the broadcast weight/bias bus toward the PE cores.
interface pe_weight_loader_if;
    import pe_weight_loader_pkg::*;

    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [BIAS_WIDTH-1:0]   rd_data;
    logic [WEIGHT_WIDTH-1:0] weight;
    logic [CORE_NUM-1:0]     weight_valid;
    logic [BIAS_WIDTH-1:0]   bias;
    logic [CORE_NUM-1:0]     bias_valid;

    modport master (
        output rd_en, rd_addr, weight, weight_valid, bias, bias_valid,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, weight, weight_valid, bias, bias_valid,
        output rd_data
    );

endinterface

// File: rtl/pe_weight_loader.sv
// Streams one 3x3 kernel plus bias per PE core out of the weight buffer into the cores.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; counters hold
// ST_READ  | issuing one buffer read per unpaused cycle
// ST_DRAIN | last read's data being delivered to its core
// ST_DONE  | one-cycle completion pulse
module pe_weight_loader
    import pe_weight_loader_pkg::*;
(
    input  logic                  DSP_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CORE_CNT_W-1:0] core_cnt,
    input  logic                  pause,
    output logic                  busy,
    output logic                  done,
    pe_weight_loader_if.master    wl
);

    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(KERNEL_WORDS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ELEM_W-1:0]       elem_left_q;
    logic [CORE_IDX_W-1:0]   core_idx_q;
    logic [CORE_IDX_W-1:0]   cores_left_q;

    logic                    tag_issued_q;
    logic                    tag_is_bias_q;
    logic [CORE_IDX_W-1:0]   tag_core_q;

    logic                    issue;
    logic                    load;
    logic [CORE_CNT_W-1:0]   cnt_clamped;

    // Out-of-range counts are clamped so the core index can never leave the array.
    assign cnt_clamped = (core_cnt > CORE_CNT_W'(CORE_NUM)) ? CORE_CNT_W'(CORE_NUM) : core_cnt;
    assign load        = (state_q == ST_IDLE) && start && (core_cnt != '0);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (core_cnt == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (!pause) begin
                    issue = 1'b1;
                    if ((elem_left_q == '0) && (cores_left_q == '0)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge DSP_clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            elem_left_q   <= '0;
            core_idx_q    <= '0;
            cores_left_q  <= '0;
            tag_issued_q  <= 1'b0;
            tag_is_bias_q <= 1'b0;
            tag_core_q    <= '0;
        end else begin
            state_q       <= state_d;
            tag_issued_q  <= issue;
            tag_is_bias_q <= (elem_left_q == '0);
            tag_core_q    <= core_idx_q;

            if (load) begin
                addr_q       <= base_addr;
                elem_left_q  <= ELEM_LAST;
                core_idx_q   <= '0;
                cores_left_q <= CORE_IDX_W'(cnt_clamped - CORE_CNT_W'(1));
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                // elem_left counts down to the bias word, then rolls over to the next core
                if (elem_left_q == '0) begin
                    elem_left_q  <= ELEM_LAST;
                    core_idx_q   <= core_idx_q + CORE_IDX_W'(1);
                    cores_left_q <= cores_left_q - CORE_IDX_W'(1);
                end else begin
                    elem_left_q  <= elem_left_q - ELEM_W'(1);
                end
            end
        end
    end

    assign wl.rd_en        = issue;
    assign wl.rd_addr      = addr_q;
    assign wl.weight       = wl.rd_data[WEIGHT_WIDTH-1:0];
    assign wl.bias         = wl.rd_data;
    assign wl.weight_valid = (tag_issued_q && !tag_is_bias_q) ? core_onehot(tag_core_q) : '0;
    assign wl.bias_valid   = (tag_issued_q &&  tag_is_bias_q) ? core_onehot(tag_core_q) : '0;

    assign busy = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: spec vectors, reset-mid-load sequence and random loads vs a cycle model.
module tb_pe_weight_loader;
    import pe_weight_loader_pkg::*;

    localparam int NCYC = 512;

    logic                  DSP_clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CORE_CNT_W-1:0] core_cnt;
    logic                  pause;
    logic                  busy;
    logic                  done;

    int n_assert = 0;
    int n_fail   = 0;

    pe_weight_loader_if bus();

    pe_weight_loader dut (
        .DSP_clk   (DSP_clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .core_cnt  (core_cnt),
        .pause     (pause),
        .busy      (busy),
        .done      (done),
        .wl        (bus)
    );

    always #5 DSP_clk = ~DSP_clk;

    logic [BIAS_WIDTH-1:0] mem [0:65535];

    always @(posedge DSP_clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    function automatic void check(input string name, input longint got, input longint exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endfunction

    typedef struct {
        logic [15:0] base;
        int          n;
        int          plo;
        int          phi;
        int          restart_c;
        int          exp_done;
    } vec_t;

    // Reference: reads occur one per unpaused cycle from cycle 1 until 10*n words are read;
    // each read is delivered the following cycle; done two cycles after the last read.
    task automatic run_load(input logic [15:0] base, input int n, input int plo, input int phi,
                            input int prand, input int restart_c, input int exp_done);
        int issue_idx [NCYC];
        bit pz [NCYC];
        int wcnt [CORE_NUM];
        int bcnt [CORE_NUM];
        int t, r, last, done_c, obs_done, prev, core;
        logic [15:0] a;
        logic [CORE_NUM-1:0] ewv, ebv;

        for (int c = 0; c < NCYC; c++) begin
            issue_idx[c] = -1;
            pz[c] = (c >= plo && c <= phi) ||
                    (c < 300 && prand > 0 && int'($urandom_range(99)) < prand);
        end
        for (int k = 0; k < CORE_NUM; k++) begin
            wcnt[k] = 0;
            bcnt[k] = 0;
        end
        t = 1;
        r = 0;
        while (r < KERNEL_WORDS * n) begin
            if (!pz[t]) begin
                issue_idx[t] = r;
                r++;
            end
            t++;
        end
        last     = t - 1;
        done_c   = (n == 0) ? 1 : last + 2;
        obs_done = -1;

        for (int c = 0; c <= done_c + 3; c++) begin
            @(posedge DSP_clk);
            #1;
            start     = (c == 0) || (c == restart_c);
            base_addr = (c == 0) ? base : ~base;
            core_cnt  = (c == 0) ? CORE_CNT_W'(n) : CORE_CNT_W'(CORE_NUM);
            pause     = pz[c];
            @(negedge DSP_clk);
            if (done && obs_done < 0) obs_done = c;

            check("rd_en", bus.rd_en, issue_idx[c] >= 0);
            if (issue_idx[c] >= 0) begin
                a = base + 16'(issue_idx[c]);
                check("rd_addr", bus.rd_addr, a);
            end

            prev = (c > 0) ? issue_idx[c-1] : -1;
            ewv  = '0;
            ebv  = '0;
            if (prev >= 0) begin
                core = prev / KERNEL_WORDS;
                a    = base + 16'(prev);
                if (prev % KERNEL_WORDS == KERNEL_WORDS - 1) begin
                    ebv[core] = 1'b1;
                    check("bias", bus.bias, mem[a]);
                end else begin
                    ewv[core] = 1'b1;
                    check("weight", bus.weight, mem[a][WEIGHT_WIDTH-1:0]);
                end
            end
            check("weight_valid", bus.weight_valid, ewv);
            check("bias_valid", bus.bias_valid, ebv);
            check("busy", busy, (n > 0) && (c >= 1) && (c <= last + 1));
            check("done", done, c == done_c);

            for (int k = 0; k < CORE_NUM; k++) begin
                wcnt[k] += int'(bus.weight_valid[k]);
                bcnt[k] += int'(bus.bias_valid[k]);
            end
        end
        start = 1'b0;
        pause = 1'b0;

        check("done_cycle", obs_done, done_c);
        if (exp_done >= 0) check("done_cycle_nominal", obs_done, exp_done);
        for (int k = 0; k < CORE_NUM; k++) begin
            check("wv_count", wcnt[k], (k < n) ? WEIGHTS_PER_CORE : 0);
            check("bv_count", bcnt[k], (k < n) ? 1 : 0);
        end
    endtask

    vec_t vecs [7];
    int   seen;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        base_addr = '0;
        core_cnt  = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 20; i++) mem[16'h0100 + i] = 32'(i);

        vecs[0] = '{16'h0100, 2, -1, -1, -1, 22};
        vecs[1] = '{16'h0200, 1,  4,  6, -1, 15};
        vecs[2] = '{16'h0000, 0, -1, -1, -1,  1};
        vecs[3] = '{16'h0300, 2, -1, -1,  7, 22};
        vecs[4] = '{16'h0400, 1, -1, -1, 12, 12};
        vecs[5] = '{16'hFFFB, 1, -1, -1, -1, 12};
        vecs[6] = '{16'h1000, 8, -1, -1, -1, 82};

        repeat (3) @(posedge DSP_clk);
        @(negedge DSP_clk);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_weight_valid", bus.weight_valid, 0);
        check("reset_bias_valid", bus.bias_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge DSP_clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_load(vecs[i].base, vecs[i].n, vecs[i].plo, vecs[i].phi, 0,
                     vecs[i].restart_c, vecs[i].exp_done);
        end

        // Reset asserted in cycle 5 of a 3-core load.
        for (int c = 0; c <= 6; c++) begin
            @(posedge DSP_clk);
            #1;
            start     = (c == 0);
            base_addr = 16'h0500;
            core_cnt  = CORE_CNT_W'(3);
            pause     = 1'b0;
            rst_n     = (c != 5);
            @(negedge DSP_clk);
        end
        check("rstmid_rd_en", bus.rd_en, 0);
        check("rstmid_rd_addr", bus.rd_addr, 0);
        check("rstmid_weight_valid", bus.weight_valid, 0);
        check("rstmid_bias_valid", bus.bias_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        seen = 0;
        repeat (30) begin
            @(posedge DSP_clk);
            #1 start = 1'b0;
            @(negedge DSP_clk);
            if (done || bus.rd_en || (|bus.weight_valid) || (|bus.bias_valid) || busy) seen++;
        end
        check("rstmid_quiet_cycles", seen, 0);
        run_load(16'h0700, 3, -1, -1, 0, -1, 32);

        for (int i = 0; i < 12; i++) begin
            run_load(16'($urandom_range(65535)), int'($urandom_range(CORE_NUM)), -1, -1,
                     int'($urandom_range(40)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
